// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores against a byte-lane RAM, with illegal-access flagging.
// Latency: resp_valid_o rises WAIT_CYCLES+1 cycles after the accept edge; store commit / load capture on that edge.
// Backpressure: one access in flight; req_ready_o only in IDLE, response held stable until resp_ready_i.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_unsigned_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // Backing byte array; contents deliberately survive reset.
    logic [7:0] ram [DEPTH];

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    req_we_q, req_we_d;
    logic [31:0]             req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
    logic [1:0]              req_type_q, req_type_d;
    logic                    req_unsigned_q, req_unsigned_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic                    commit;
    logic                    ram_we;
    logic                    acc_err;
    logic [3:0]              lane_en;
    logic [ADDR_WIDTH-1:0]   lane_idx [4];
    logic [7:0]              rd_byte  [4];
    logic [DATA_WIDTH-1:0]   load_ext;

    // Byte lanes touched by the latched access, their RAM indices and current contents.
    always_comb begin
        lane_en = 4'b0000;
        case (req_type_q)
            2'b00:   lane_en = 4'b0001;
            2'b01:   lane_en = 4'b0011;
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            lane_idx[i] = req_addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
            rd_byte[i]  = ram[lane_idx[i]];
        end
    end

    // Legality check and load-data extension for the latched access.
    always_comb begin
        acc_err = 1'b0;
        if (req_type_q == 2'b11)                           acc_err = 1'b1;
        if (req_type_q == 2'b01 && req_addr_q[0])          acc_err = 1'b1;
        if (req_type_q == 2'b10 && req_addr_q[1:0] != 2'b00) acc_err = 1'b1;
        if (|req_addr_q[31:ADDR_WIDTH])                    acc_err = 1'b1;

        load_ext = '0;
        case (req_type_q)
            2'b00: load_ext = req_unsigned_q ? {24'd0, rd_byte[0]}
                                             : {{24{rd_byte[0][7]}}, rd_byte[0]};
            2'b01: load_ext = req_unsigned_q ? {16'd0, rd_byte[1], rd_byte[0]}
                                             : {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            2'b10: load_ext = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            default: load_ext = '0;
        endcase
    end

    // FSM next-state: latch request in IDLE, count out wait states, commit on entry to RESP.
    // WAIT always lasts WAIT_CYCLES+1 cycles so the response latency is WAIT_CYCLES+1 even at zero.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_we_d       = req_we_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        req_type_d     = req_type_q;
        req_unsigned_d = req_unsigned_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        commit         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_we_d       = req_we_i;
                    req_addr_d     = req_addr_i;
                    req_wdata_d    = req_wdata_i;
                    req_type_d     = req_type_i;
                    req_unsigned_d = req_unsigned_i;
                    cnt_d          = WAIT_INIT;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit       = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (req_we_q || acc_err) ? '0 : load_ext;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_we = commit && req_we_q && !acc_err;

    // State and request/response registers; reset discards any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            req_we_q       <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_type_q     <= 2'b00;
            req_unsigned_q <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_we_q       <= req_we_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_type_q     <= req_type_d;
            req_unsigned_q <= req_unsigned_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
        end
    end

    // Store commit: write only the enabled byte lanes, right-aligned data goes to ascending addresses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && lane_en[i]) ram[lane_idx[i]] <= req_wdata_q[8*i +: 8];
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 15) driven in lockstep.
// Expected responses are queued at issue and compared as each instance responds, with latency checks.
// Shared response-ready lets the hold test stall all instances at once.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_type = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_ready = 1'b1;

    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_err;
    logic [31:0] resp_rdata [3];

    int errors = 0;
    int checks = 0;

    localparam int WAITS [3] = '{1, 0, 15};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_type_i(req_type),
        .req_unsigned_i(req_unsigned),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_type_i(req_type),
        .req_unsigned_i(req_unsigned),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[2]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_type_i(req_type),
        .req_unsigned_i(req_unsigned),
        .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata[2]), .resp_err_o(resp_err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] typ, input logic uns);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_type     = typ;
        req_unsigned = uns;
    endtask

    // Issue one access to all instances, then compare each response against the queue head.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] typ, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err);
        sb_t e;
        bit  seen [3];
        int  nseen;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        check({tag, ":req_ready"}, {29'd0, req_ready}, 32'h7);
        drive(we, addr, wdata, typ, uns);
        tick();
        req_valid = 1'b0;
        nseen = 0;
        for (int d = 0; d < 3; d++) seen[d] = 1'b0;
        for (int cyc = 1; cyc <= 20 && nseen < 3; cyc++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && resp_valid[d]) begin
                    seen[d] = 1'b1;
                    nseen++;
                    check($sformatf("%s:lat_w%0d", tag, WAITS[d]), 32'(cyc), 32'(WAITS[d] + 1));
                    check($sformatf("%s:rdata_w%0d", tag, WAITS[d]), resp_rdata[d], sb_q[0].rdata);
                    check($sformatf("%s:err_w%0d", tag, WAITS[d]), {31'd0, resp_err[d]}, {31'd0, sb_q[0].err});
                end
            end
        end
        for (int d = 0; d < 3; d++)
            check($sformatf("%s:responded_w%0d", tag, WAITS[d]), {31'd0, seen[d]}, 32'd1);
        void'(sb_q.pop_front());
        tick();
    endtask

    task automatic idle_check(input string tag);
        check({tag, ":req_ready"}, {29'd0, req_ready}, 32'h7);
        check({tag, ":resp_valid"}, {29'd0, resp_valid}, 32'h0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s:rdata_w%0d", tag, WAITS[d]), resp_rdata[d], 32'h0);
            check($sformatf("%s:err_w%0d", tag, WAITS[d]), {31'd0, resp_err[d]}, 32'h0);
        end
    endtask

    initial begin
        sb_t e;
        bit  all_valid;

        // Reset and post-reset state
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        idle_check("reset");

        // Word store then word load
        txn("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        txn("lw_10a", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte store, signed/unsigned byte loads, lane preservation
        txn("sb_11",  1'b1, 32'h11, 32'h12345680, 2'b00, 1'b0, 32'h0, 1'b0);
        txn("lb_11",  1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        txn("lbu_11", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        txn("lw_10b", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD80EF, 1'b0);

        // Half store and half loads
        txn("sh_12",  1'b1, 32'h12, 32'h77778001, 2'b01, 1'b0, 32'h0, 1'b0);
        txn("lh_12",  1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        txn("lhu_12", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h00008001, 1'b0);
        txn("lw_10c", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h800180EF, 1'b0);

        // Illegal accesses: no side effect, zero data
        txn("lh_13_mis",  1'b0, 32'h13,   32'h0,        2'b01, 1'b0, 32'h0, 1'b1);
        txn("sw_12_mis",  1'b1, 32'h12,   32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1);
        txn("lw_10d",     1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h800180EF, 1'b0);
        txn("type11",     1'b0, 32'h0,    32'h0,        2'b11, 1'b0, 32'h0, 1'b1);
        txn("lw_1000",    1'b0, 32'h1000, 32'h0,        2'b10, 1'b0, 32'h0, 1'b1);
        txn("sb_1010",    1'b1, 32'h1010, 32'h000000AA, 2'b00, 1'b0, 32'h0, 1'b1);
        txn("lbu_10",     1'b0, 32'h10,   32'h0,        2'b00, 1'b1, 32'h000000EF, 1'b0);

        // Response backpressure: outputs hold, new requests ignored
        resp_ready = 1'b0;
        e.rdata = 32'h800180EF;
        e.err   = 1'b0;
        sb_q.push_back(e);
        drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        tick();
        req_valid = 1'b0;
        all_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !all_valid; cyc++) begin
            tick();
            all_valid = (resp_valid == 3'b111);
        end
        check("hold:all_valid", {31'd0, all_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h10, 32'h0, 2'b10, 1'b0);
            tick();
            check($sformatf("hold%0d:resp_valid", k), {29'd0, resp_valid}, 32'h7);
            check($sformatf("hold%0d:req_ready", k), {29'd0, req_ready}, 32'h0);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("hold%0d:rdata_w%0d", k, WAITS[d]), resp_rdata[d], sb_q[0].rdata);
                check($sformatf("hold%0d:err_w%0d", k, WAITS[d]), {31'd0, resp_err[d]}, {31'd0, sb_q[0].err});
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        void'(sb_q.pop_front());
        tick();
        check("hold_release:resp_valid", {29'd0, resp_valid}, 32'h0);
        check("hold_release:req_ready", {29'd0, req_ready}, 32'h7);
        txn("lw_10e", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h800180EF, 1'b0);

        // Reset during WAIT of a store: nothing written, no response
        txn("sw_20", 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_mid:resp_valid", {29'd0, resp_valid}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        idle_check("rst_mid_release");
        all_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (resp_valid != 3'b000) all_valid = 1'b1;
        end
        check("rst_mid:no_resp", {31'd0, all_valid}, 32'd0);
        txn("lw_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
